mant_mul_sched: RTL and testbench

- Shares one pipelined 24x24 mantissa multiplier (Booth partial products, reduction tree and final CPA, split into LAT register stages) between two requesters.
- Round-robin arbitration on valid/ready request ports.
- Issues registered operands to the multiplier and tracks each in-flight operation's requester ID.
- Returns 48-bit products in issue order through a credit-protected result FIFO with a single valid/ready response port.

---
 rtl/mant_mul_sched_if.sv | 56 +++++
 rtl/mant_mul_sched.sv | 137 +++++++++++++
 tb/tb_mant_mul_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mant_mul_sched_if.sv
// Purpose: request/issue/response bundle for the shared mantissa-multiplier scheduler.
// Latency: n/a (wires only).
// Backpressure: requesters are stalled by req*_ready, the consumer throttles through rsp_ready.
//
// Signals: req0_*/req1_* valid/ready request ports with WA-bit operands;
//          mul_en/mul_a/mul_b to the external multiplier and mul_z back from it;
//          rsp_valid/rsp_ready/rsp_id/rsp_z response port; busy status.
// WA/WZ must match the parameters of the mant_mul_sched instance this bundle is bound to.
interface mant_mul_sched_if #(
  parameter int WA = 24,
  parameter int WZ = 48
);
  logic          req0_valid;
  logic          req0_ready;
  logic [WA-1:0] req0_a;
  logic [WA-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [WA-1:0] req1_a;
  logic [WA-1:0] req1_b;
  logic          mul_en;
  logic [WA-1:0] mul_a;
  logic [WA-1:0] mul_b;
  logic [WZ-1:0] mul_z;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [WZ-1:0] rsp_z;
  logic          busy;

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output mul_en, mul_a, mul_b,
    input  mul_z,
    output rsp_valid, rsp_id, rsp_z,
    input  rsp_ready,
    output busy
  );

  // Environment side: requesters, multiplier and response consumer.
  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  mul_en, mul_a, mul_b,
    output mul_z,
    input  rsp_valid, rsp_id, rsp_z,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/mant_mul_sched.sv
// Purpose: round-robin share of one pipelined 24x24 mantissa multiplier between two requesters.
// Latency: accept in cycle c -> mul_en in c+1 -> rsp_valid in c+LAT+2.
// Backpressure: ready drops when in-flight + buffered results reach DEPTH; rsp_ready stalls the FIFO head.
//
// Ports: clk, rst (synchronous, active-high); bus (mant_mul_sched_if.slave) carrying the two
//        request ports, the multiplier issue/return signals, the response port and busy.
module mant_mul_sched #(
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  parameter int WA    = 24,
  parameter int WZ    = 48
) (
  input logic             clk,
  input logic             rst,
  mant_mul_sched_if.slave bus
);
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              PW      = $clog2(DEPTH);
  localparam int              FW      = WZ + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0]   LAST_P  = PW'(DEPTH - 1);

  // Arbitration and credit.
  logic [CW-1:0] used_q, used_d;
  logic          last_q, last_d;   // 1: requester 1 was granted most recently
  logic          can_accept, gnt0, gnt1, accept;

  // Issue register and in-flight tag pipeline.
  logic          mul_en_q, mul_en_d;
  logic          issue_id_q, issue_id_d;
  logic [WA-1:0] mul_a_q, mul_a_d;
  logic [WA-1:0] mul_b_q, mul_b_d;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;

  // Result FIFO.
  logic [FW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, fifo_vld, fifo_full;

  always_comb begin
    // Credit counts from the accept edge, so a pop only frees a slot for the next cycle.
    can_accept = (used_q < DEPTH_C);
    gnt0       = !rst && can_accept && bus.req0_valid && (!bus.req1_valid || last_q);
    gnt1       = !rst && can_accept && bus.req1_valid && (!bus.req0_valid || !last_q);
    accept     = gnt0 || gnt1;

    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end

    mul_en_d   = accept;
    issue_id_d = gnt1;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    if (gnt0) begin
      mul_a_d = bus.req0_a;
      mul_b_d = bus.req0_b;
    end else if (gnt1) begin
      mul_a_d = bus.req1_a;
      mul_b_d = bus.req1_b;
    end

    // Stage 0 is fed by the issue register, so the tail lines up with mul_z LAT cycles after mul_en.
    tag_vld_d = (tag_vld_q << 1) | LAT'(mul_en_q);
    tag_id_d  = (tag_id_q << 1) | LAT'(issue_id_q);

    push      = tag_vld_q[LAT-1];
    fifo_vld  = (cnt_q != '0);
    fifo_full = (cnt_q == DEPTH_C);
    pop       = fifo_vld && bus.rsp_ready;

    used_d = used_q + CW'(accept) - CW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);

    wr_d = wr_q;
    if (push) begin
      wr_d = (wr_q == LAST_P) ? '0 : wr_q + PW'(1);
    end
    rd_d = rd_q;
    if (pop) begin
      rd_d = (rd_q == LAST_P) ? '0 : rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used_q     <= '0;
      last_q     <= 1'b1;
      mul_en_q   <= 1'b0;
      issue_id_q <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      used_q     <= used_d;
      last_q     <= last_d;
      mul_en_q   <= mul_en_d;
      issue_id_q <= issue_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      // Credit accounting guarantees a free slot for every returning product.
      assert (!(push && fifo_full));
    end
  end

  // Storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {tag_id_q[LAT-1], bus.mul_z};
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.mul_en     = mul_en_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.rsp_valid  = fifo_vld;
  assign bus.rsp_id     = mem_q[rd_q][FW-1];
  assign bus.rsp_z      = mem_q[rd_q][WZ-1:0];
  // used_q covers exactly the in-flight plus buffered operations.
  assign bus.busy       = (used_q != '0);
endmodule

// File: tb/tb_mant_mul_sched.sv
// Purpose: directed self-checking bench for mant_mul_sched with a LAT-stage multiplier model.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low and pulsing it.
module tb_mant_mul_sched;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;
  localparam int WA    = 24;
  localparam int WZ    = 48;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  int   base_acc, base_rsp, drops, ghost;
  logic [WZ:0] exp_q[$];
  logic [WZ-1:0] zp [LAT];

  mant_mul_sched_if #(.WA(WA), .WZ(WZ)) bus_if ();

  mant_mul_sched #(.LAT(LAT), .DEPTH(DEPTH), .WA(WA), .WZ(WZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pipelined multiplier model: product appears LAT cycles after its operands.
  always @(posedge clk) begin
    zp[0] <= 48'(bus_if.mul_a) * 48'(bus_if.mul_b);
    for (int i = 1; i < LAT; i++) zp[i] <= zp[i-1];
  end
  assign bus_if.mul_z = zp[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (bus_if.busy && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, bus_if.busy, 0);
  endtask

  // Scoreboard: every accept enqueues {id, a*b}; every pop must match the oldest entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.req0_ready) begin
        exp_q.push_back({1'b0, 48'(bus_if.req0_a) * 48'(bus_if.req0_b)});
        acc_cnt++;
      end
      if (bus_if.req1_ready) begin
        exp_q.push_back({1'b1, 48'(bus_if.req1_a) * 48'(bus_if.req1_b)});
        acc_cnt++;
      end
      if (bus_if.rsp_valid && bus_if.rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_order", {bus_if.rsp_id, bus_if.rsp_z}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus_if.req0_valid = 0; bus_if.req0_a = '0; bus_if.req0_b = '0;
    bus_if.req1_valid = 0; bus_if.req1_a = '0; bus_if.req1_b = '0;
    bus_if.rsp_ready  = 0;

    // Reset state; ready must stay low while rst is asserted.
    repeat (2) @(posedge clk);
    #1;
    bus_if.req0_valid = 1; bus_if.req0_a = 24'd1; bus_if.req0_b = 24'd1;
    mid();
    chk("rst_req0_ready", bus_if.req0_ready, 0);
    chk("rst_mul_en", bus_if.mul_en, 0);
    chk("rst_mul_a", bus_if.mul_a, 0);
    chk("rst_mul_b", bus_if.mul_b, 0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_busy", bus_if.busy, 0);

    // Contention from reset: grants alternate starting with requester 0.
    nxt();
    rst = 1'b0;
    bus_if.rsp_ready = 1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) nxt();
      bus_if.req0_valid = 1; bus_if.req0_a = 24'(i + 1);   bus_if.req0_b = 24'd2;
      bus_if.req1_valid = 1; bus_if.req1_a = 24'(100 + i); bus_if.req1_b = 24'd3;
      mid();
      chk("arb_req0_ready", bus_if.req0_ready, (i % 2 == 0));
      chk("arb_req1_ready", bus_if.req1_ready, (i % 2 == 1));
    end
    nxt();
    bus_if.req0_valid = 0; bus_if.req1_valid = 0;
    wait_idle(30, "arb_drain_busy");
    // Last grant went to requester 0; idle cycles must not move the pointer.
    nxt();
    bus_if.req0_valid = 1; bus_if.req0_a = 24'd9;  bus_if.req0_b = 24'd9;
    bus_if.req1_valid = 1; bus_if.req1_a = 24'd10; bus_if.req1_b = 24'd10;
    mid();
    chk("idle_ptr_req1_ready", bus_if.req1_ready, 1);
    chk("idle_ptr_req0_ready", bus_if.req0_ready, 0);
    nxt();
    bus_if.req0_valid = 0; bus_if.req1_valid = 0;
    wait_idle(30, "idle_drain_busy");

    // Single op: 3*5, accept in cycle A.
    nxt();
    bus_if.req0_valid = 1; bus_if.req0_a = 24'd3; bus_if.req0_b = 24'd5;
    mid();
    chk("single_accept", bus_if.req0_ready, 1);
    nxt();
    bus_if.req0_valid = 0;
    mid();
    chk("single_mul_en", bus_if.mul_en, 1);
    chk("single_mul_a", bus_if.mul_a, 3);
    chk("single_mul_b", bus_if.mul_b, 5);
    chk("single_busy", bus_if.busy, 1);
    nxt(); mid();
    chk("single_mul_en_off", bus_if.mul_en, 0);
    chk("single_mul_a_hold", bus_if.mul_a, 3);
    nxt(); mid();
    nxt(); mid();
    chk("single_rsp_early", bus_if.rsp_valid, 0);
    nxt(); mid();
    chk("single_rsp_valid", bus_if.rsp_valid, 1);
    chk("single_rsp_id", bus_if.rsp_id, 0);
    chk("single_rsp_z", bus_if.rsp_z, 48'd15);
    nxt(); mid();
    chk("single_busy_fall", bus_if.busy, 0);
    chk("single_rsp_gone", bus_if.rsp_valid, 0);

    // Backpressure: credits run out after DEPTH accepts.
    nxt();
    bus_if.rsp_ready = 0;
    base_acc = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) nxt();
      bus_if.req0_valid = 1; bus_if.req0_a = 24'(i + 20); bus_if.req0_b = 24'd7;
      mid();
    end
    chk("bp_accepts", acc_cnt - base_acc, 8);
    chk("bp_ready_low", bus_if.req0_ready, 0);
    chk("bp_rsp_valid", bus_if.rsp_valid, 1);
    nxt();
    bus_if.rsp_ready = 1;
    mid();
    chk("bp_no_bypass", bus_if.req0_ready, 0);
    nxt();
    bus_if.rsp_ready = 0;
    mid();
    chk("bp_credit_back", bus_if.req0_ready, 1);
    nxt(); mid();
    chk("bp_ready_low_again", bus_if.req0_ready, 0);
    chk("bp_accepts_total", acc_cnt - base_acc, 9);
    nxt();
    bus_if.req0_valid = 0;
    bus_if.rsp_ready  = 1;
    wait_idle(40, "bp_drain_busy");
    chk("bp_all_returned", exp_q.size(), 0);

    // Streaming: one accept per cycle for 100 cycles.
    base_acc = acc_cnt;
    base_rsp = rsp_cnt;
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      nxt();
      bus_if.req1_valid = 1; bus_if.req1_a = 24'(i * 3 + 1); bus_if.req1_b = 24'(i + 1000);
      mid();
      if (!bus_if.req1_ready) drops++;
    end
    nxt();
    bus_if.req1_valid = 0;
    mid();
    chk("stream_accepts", acc_cnt - base_acc, 100);
    chk("stream_ready_drops", drops, 0);
    wait_idle(30, "stream_drain_busy");
    chk("stream_responses", rsp_cnt - base_rsp, 100);
    chk("stream_all_returned", exp_q.size(), 0);

    // Operand extremes.
    nxt();
    bus_if.req0_valid = 1; bus_if.req0_a = 24'hFFFFFF; bus_if.req0_b = 24'hFFFFFF;
    mid();
    chk("ext_acc0", bus_if.req0_ready, 1);
    nxt();
    bus_if.req0_valid = 0;
    bus_if.req1_valid = 1; bus_if.req1_a = 24'd0; bus_if.req1_b = 24'h123456;
    mid();
    chk("ext_acc1", bus_if.req1_ready, 1);
    nxt();
    bus_if.req1_valid = 0;
    bus_if.req0_valid = 1; bus_if.req0_a = 24'hABCDEF; bus_if.req0_b = 24'd0;
    mid();
    chk("ext_acc2", bus_if.req0_ready, 1);
    nxt();
    bus_if.req0_valid = 0;
    mid();
    nxt(); mid();
    nxt(); mid();
    chk("ext_max_z", bus_if.rsp_z, 48'hFFFFFE000001);
    chk("ext_max_id", bus_if.rsp_id, 0);
    nxt(); mid();
    chk("ext_a0_z", bus_if.rsp_z, 48'd0);
    chk("ext_a0_id", bus_if.rsp_id, 1);
    nxt(); mid();
    chk("ext_b0_z", bus_if.rsp_z, 48'd0);
    chk("ext_b0_id", bus_if.rsp_id, 0);
    wait_idle(20, "ext_drain_busy");

    // Reset mid-flight: three ops, then a one-cycle reset before any result lands.
    nxt();
    bus_if.req0_valid = 1; bus_if.req0_a = 24'd11; bus_if.req0_b = 24'd13;
    mid();
    nxt();
    bus_if.req0_valid = 0;
    bus_if.req1_valid = 1; bus_if.req1_a = 24'd17; bus_if.req1_b = 24'd19;
    mid();
    nxt();
    bus_if.req1_valid = 0;
    bus_if.req0_valid = 1; bus_if.req0_a = 24'd23; bus_if.req0_b = 24'd29;
    mid();
    chk("mrst_busy_before", bus_if.busy, 1);
    nxt();
    bus_if.req0_valid = 0;
    mid();
    nxt();
    rst = 1'b1;
    exp_q.delete();
    bus_if.req0_valid = 1;
    mid();
    chk("mrst_ready_in_rst", bus_if.req0_ready, 0);
    nxt();
    rst = 1'b0;
    bus_if.req0_valid = 0;
    mid();
    chk("mrst_mul_en", bus_if.mul_en, 0);
    chk("mrst_mul_a", bus_if.mul_a, 0);
    chk("mrst_mul_b", bus_if.mul_b, 0);
    chk("mrst_busy", bus_if.busy, 0);
    chk("mrst_rsp_valid", bus_if.rsp_valid, 0);
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      nxt(); mid();
      if (bus_if.rsp_valid) ghost++;
    end
    chk("mrst_no_ghost_rsp", ghost, 0);
    chk("mrst_busy_after", bus_if.busy, 0);

    // After reset, requester 0 wins the first contention and latency is unchanged.
    nxt();
    bus_if.req0_valid = 1; bus_if.req0_a = 24'd5; bus_if.req0_b = 24'd6;
    bus_if.req1_valid = 1; bus_if.req1_a = 24'd7; bus_if.req1_b = 24'd8;
    mid();
    chk("post_rst_req0_wins", bus_if.req0_ready, 1);
    chk("post_rst_req1_wait", bus_if.req1_ready, 0);
    nxt();
    bus_if.req0_valid = 0;
    mid();
    chk("post_rst_req1_next", bus_if.req1_ready, 1);
    nxt();
    bus_if.req1_valid = 0;
    mid();
    nxt(); mid();
    nxt(); mid();
    chk("post_rst_rsp_early", bus_if.rsp_valid, 0);
    nxt(); mid();
    chk("post_rst_rsp_valid", bus_if.rsp_valid, 1);
    chk("post_rst_rsp_id0", bus_if.rsp_id, 0);
    chk("post_rst_rsp_z0", bus_if.rsp_z, 48'd30);
    nxt(); mid();
    chk("post_rst_rsp_id1", bus_if.rsp_id, 1);
    chk("post_rst_rsp_z1", bus_if.rsp_z, 48'd56);
    wait_idle(20, "post_rst_drain_busy");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
